// File: rtl/saes_pkg.sv
// Shared simplified-AES definitions: widths, key-schedule round constants and key-expansion FSM states.
package saes_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 8;
    localparam int KEY_W  = 16;

    localparam logic [WORD_W-1:0] RCON1 = 8'h80;
    localparam logic [WORD_W-1:0] RCON2 = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RND1 = 2'd1,
        RND2 = 2'd2
    } state_t;

endpackage

// File: rtl/saes_sub_nib8.sv
// Byte-wide SubNib: the 4-bit S-AES encryption S-box applied to each nibble independently.
module saes_sbox4
    import saes_pkg::*;
(
    input  logic [NIB_W-1:0] nib_in,
    output logic [NIB_W-1:0] nib_out
);

    always_comb begin
        nib_out = 4'h0;
        case (nib_in)
            4'h0: nib_out = 4'h9;
            4'h1: nib_out = 4'h4;
            4'h2: nib_out = 4'hA;
            4'h3: nib_out = 4'hB;
            4'h4: nib_out = 4'hD;
            4'h5: nib_out = 4'h1;
            4'h6: nib_out = 4'h8;
            4'h7: nib_out = 4'h5;
            4'h8: nib_out = 4'h6;
            4'h9: nib_out = 4'h2;
            4'hA: nib_out = 4'h0;
            4'hB: nib_out = 4'h3;
            4'hC: nib_out = 4'hC;
            4'hD: nib_out = 4'hE;
            4'hE: nib_out = 4'hF;
            4'hF: nib_out = 4'h7;
            default: nib_out = 4'h0;
        endcase
    end

endmodule

module saes_sub_nib8
    import saes_pkg::*;
(
    input  logic [WORD_W-1:0] byte_in,
    output logic [WORD_W-1:0] byte_out
);

    saes_sbox4 u_sbox_hi (
        .nib_in  (byte_in[WORD_W-1:NIB_W]),
        .nib_out (byte_out[WORD_W-1:NIB_W])
    );

    saes_sbox4 u_sbox_lo (
        .nib_in  (byte_in[NIB_W-1:0]),
        .nib_out (byte_out[NIB_W-1:0])
    );

endmodule

// File: rtl/saes_key_expand.sv
// Sequential S-AES key expansion producing rk0/rk1/rk2 over a start/busy/valid handshake.
// Optional SAES_KEY_CACHE_EN: a start repeating the currently valid key is absorbed in IDLE.
module saes_key_expand
    import saes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    output logic [KEY_W-1:0] rk0,
    output logic [KEY_W-1:0] rk1,
    output logic [KEY_W-1:0] rk2
);

    state_t state, state_nxt;

    logic              cache_hit;
    logic              accept;
    logic [WORD_W-1:0] w_even_prev;
    logic [WORD_W-1:0] w_odd_prev;
    logic [WORD_W-1:0] rcon;
    logic [WORD_W-1:0] sub_out;
    logic [WORD_W-1:0] w_even;
    logic [WORD_W-1:0] w_odd;

`ifdef SAES_KEY_CACHE_EN
    assign cache_hit = rk_valid && (key_in == rk0);
`else
    assign cache_hit = 1'b0;
`endif

    assign accept = (state == IDLE) && start && !cache_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RND1;
            RND1:    state_nxt = RND2;
            RND2:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RND1) || (state == RND2);
    end

    // Shared SubNib: RND1 works from {w0,w1} in rk0, RND2 from {w2,w3} in rk1.
    always_comb begin
        if (state == RND2) begin
            w_even_prev = rk1[KEY_W-1:WORD_W];
            w_odd_prev  = rk1[WORD_W-1:0];
            rcon        = RCON2;
        end else begin
            w_even_prev = rk0[KEY_W-1:WORD_W];
            w_odd_prev  = rk0[WORD_W-1:0];
            rcon        = RCON1;
        end
    end

    saes_sub_nib8 u_sub_nib (
        .byte_in  ({w_odd_prev[NIB_W-1:0], w_odd_prev[WORD_W-1:NIB_W]}),
        .byte_out (sub_out)
    );

    assign w_even = w_even_prev ^ rcon ^ sub_out;
    assign w_odd  = w_even ^ w_odd_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk0      <= '0;
            rk1      <= '0;
            rk2      <= '0;
            rk_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rk0      <= key_in;
                        rk_valid <= 1'b0;
                    end
                end
                RND1: rk1 <= {w_even, w_odd};
                RND2: begin
                    rk2      <= {w_even, w_odd};
                    rk_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_saes_key_expand.sv
// Directed-vector bench for saes_key_expand; expected round keys are hand-derived S-AES values.
module tb_saes_key_expand;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] key_in;
    logic        busy;
    logic        rk_valid;
    logic [15:0] rk0;
    logic [15:0] rk1;
    logic [15:0] rk2;

    int total = 0;
    int bad   = 0;

    saes_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk0      (rk0),
        .rk1      (rk1),
        .rk2      (rk2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic b, input logic v,
                           input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_vld"},  {31'd0, rk_valid}, {31'd0, v});
        chk({tag, "_rk0"},  {16'd0, rk0}, {16'd0, k0});
        chk({tag, "_rk1"},  {16'd0, rk1}, {16'd0, k1});
        chk({tag, "_rk2"},  {16'd0, rk2}, {16'd0, k2});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = 16'h0000;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        rst = 1'b0;
        tick();
        chk_all("idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Key A73B, full expansion
        key_in = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("a_n0", 1'b1, 1'b0, 16'hA73B, 16'h0000, 16'h0000);
        tick();
        chk_all("a_n1", 1'b1, 1'b0, 16'hA73B, 16'h1C27, 16'h0000);
        tick();
        chk_all("a_n2", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
        tick();
        chk_all("a_hold", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);

        // Repeat the same key
        key_in = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SAES_KEY_CACHE_EN
        chk_all("rep_n0", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
        tick();
        chk_all("rep_n1", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
        tick();
        chk_all("rep_n2", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
`else
        chk_all("rep_n0", 1'b1, 1'b0, 16'hA73B, 16'h1C27, 16'h7651);
        tick();
        chk_all("rep_n1", 1'b1, 1'b0, 16'hA73B, 16'h1C27, 16'h7651);
        tick();
        chk_all("rep_n2", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
`endif

        // Key 0000: old rk1/rk2 stay visible but invalid until the new set lands
        key_in = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("z_n0", 1'b1, 1'b0, 16'h0000, 16'h1C27, 16'h7651);
        tick();
        chk_all("z_n1", 1'b1, 1'b0, 16'h0000, 16'h1919, 16'h7651);
        tick();
        chk_all("z_n2", 1'b0, 1'b1, 16'h0000, 16'h1919, 16'h0D14);

        // start held high five cycles, key_in changing while busy, then back-to-back 0000
        key_in = 16'hA73B; start = 1'b1;
        tick();
        chk_all("h_n0", 1'b1, 1'b0, 16'hA73B, 16'h1919, 16'h0D14);
        key_in = 16'h1234;
        tick();
        chk_all("h_n1", 1'b1, 1'b0, 16'hA73B, 16'h1C27, 16'h0D14);
        key_in = 16'h5678;
        tick();
        chk_all("h_n2", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);
        key_in = 16'h0000;
        tick();
        chk_all("h_n3", 1'b1, 1'b0, 16'h0000, 16'h1C27, 16'h7651);
        key_in = 16'hFFFF;
        tick();
        start = 1'b0;
        chk_all("h_n4", 1'b1, 1'b0, 16'h0000, 16'h1919, 16'h7651);
        tick();
        chk_all("h_n5", 1'b0, 1'b1, 16'h0000, 16'h1919, 16'h0D14);

        // Reset asserted while in RND2
        key_in = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("r_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all("r_async", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        tick();
        chk_all("r_next", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        rst = 1'b0;
        tick();
        chk_all("r_idle", 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        key_in = 16'hA73B; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ra_n0", 1'b1, 1'b0, 16'hA73B, 16'h0000, 16'h0000);
        tick();
        chk_all("ra_n1", 1'b1, 1'b0, 16'hA73B, 16'h1C27, 16'h0000);
        tick();
        chk_all("ra_n2", 1'b0, 1'b1, 16'hA73B, 16'h1C27, 16'h7651);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
